// File: rtl/prio_encoder_pipe_if.sv
// Request/result handshake bundle for prio_encoder_pipe.
// The encoder block uses the slave side; the request source and result consumer use the master side.
interface prio_encoder_pipe_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] in_vec;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_idx;
  logic         out_none;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_vec, mode, in_valid, out_ready,
    output in_ready, out_idx, out_none, out_err, out_valid
  );

  modport master (
    output in_vec, mode, in_valid, out_ready,
    input  in_ready, out_idx, out_none, out_err, out_valid
  );
endinterface

// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) encoder with LSB, MSB, strict one-hot and round-robin modes.
// One output stage buffers the result; in_ready follows the skid-free pipeline rule.
module prio_encoder_pipe #(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst,
  prio_encoder_pipe_if.slave bus
);
  localparam int W = $clog2(N);

  localparam logic [1:0] MODE_LSB = 2'b00;
  localparam logic [1:0] MODE_MSB = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;
  localparam logic [1:0] MODE_RR  = 2'b11;

  logic [W-1:0] ptr;
  logic [W-1:0] rr_start;
  logic [W-1:0] lsb_idx;
  logic [W-1:0] msb_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic         any_set;
  logic         multi_set;
  logic [W-1:0] enc_idx;
  logic         enc_none;
  logic         enc_err;
  logic         accept;

  assign any_set   = |bus.in_vec;
  assign multi_set = |(bus.in_vec & (bus.in_vec - N'(1)));

  // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer a latch.
  always_comb begin
    lsb_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_vec[i]) lsb_idx = W'(i);
    end
  end

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_vec[i]) msb_idx = W'(i);
    end
  end

  // Search begins one past the last grant; N-1 wraps to 0 even when N is not a power of two.
  assign rr_start = (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = int'(rr_start) + k;
      if (pos >= N) pos = pos - N;
      if (!rr_found && bus.in_vec[pos]) begin
        rr_idx   = W'(pos);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    enc_idx  = '0;
    enc_none = !any_set;
    enc_err  = 1'b0;
    case (bus.mode)
      MODE_LSB: enc_idx = lsb_idx;
      MODE_MSB: enc_idx = msb_idx;
      MODE_ONE: begin
        enc_idx = lsb_idx;
        enc_err = !any_set || multi_set;
      end
      MODE_RR:  enc_idx = rr_idx;
      default:  enc_idx = '0;
    endcase
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_none  <= 1'b0;
      bus.out_err   <= 1'b0;
      ptr           <= W'(N - 1);
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_idx   <= enc_idx;
        bus.out_none  <= enc_none;
        bus.out_err   <= enc_err;
        if (bus.mode == MODE_RR && any_set) ptr <= rr_idx;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed bench for prio_encoder_pipe: vector table at N=8 plus hand-written
// back-pressure, async-reset and non-power-of-two (N=5) sequences.
module tb_prio_encoder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  prio_encoder_pipe_if #(.N(8)) bus  ();
  prio_encoder_pipe_if #(.N(5)) bus5 ();

  prio_encoder_pipe #(.N(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  prio_encoder_pipe #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  typedef struct {
    logic [1:0] mode;
    logic [7:0] vec;
    int         idx;
    bit         none;
    bit         err;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int idx, input bit none, input bit err);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".idx"},   32'(bus.out_idx),   32'(idx));
    check({tag, ".none"},  32'(bus.out_none),  32'(none));
    check({tag, ".err"},   32'(bus.out_err),   32'(err));
  endtask

  task automatic drive(input logic [1:0] mode, input logic [7:0] vec);
    bus.mode     = mode;
    bus.in_vec   = vec;
    bus.in_valid = 1'b1;
  endtask

  task automatic step5(input string tag, input logic [1:0] mode, input logic [4:0] vec,
                       input int idx, input bit none, input bit err);
    bus5.mode     = mode;
    bus5.in_vec   = vec;
    bus5.in_valid = 1'b1;
    @(negedge clk);
    check({tag, ".valid"}, 32'(bus5.out_valid), 32'd1);
    check({tag, ".idx"},   32'(bus5.out_idx),   32'(idx));
    check({tag, ".none"},  32'(bus5.out_none),  32'(none));
    check({tag, ".err"},   32'(bus5.out_err),   32'(err));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{2'b00, 8'(1 << i), i, 1'b0, 1'b0};
    tbl[8]  = '{2'b00, 8'h5A, 1, 1'b0, 1'b0};
    tbl[9]  = '{2'b01, 8'h5A, 6, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 8'h00, 0, 1'b1, 1'b0};
    tbl[11] = '{2'b01, 8'h00, 0, 1'b1, 1'b0};
    tbl[12] = '{2'b10, 8'h10, 4, 1'b0, 1'b0};
    tbl[13] = '{2'b10, 8'h30, 4, 1'b0, 1'b1};
    tbl[14] = '{2'b10, 8'h00, 0, 1'b1, 1'b1};
    tbl[15] = '{2'b11, 8'h91, 0, 1'b0, 1'b0};
    tbl[16] = '{2'b11, 8'h91, 4, 1'b0, 1'b0};
    tbl[17] = '{2'b11, 8'h91, 7, 1'b0, 1'b0};
    tbl[18] = '{2'b11, 8'h91, 0, 1'b0, 1'b0};
    tbl[19] = '{2'b11, 8'h00, 0, 1'b1, 1'b0};
    tbl[20] = '{2'b11, 8'h91, 4, 1'b0, 1'b0};
    tbl[21] = '{2'b10, 8'h81, 0, 1'b0, 1'b1};
    tbl[22] = '{2'b11, 8'h91, 7, 1'b0, 1'b0};

    bus.in_vec     = '0;
    bus.mode       = 2'b00;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus5.in_vec    = '0;
    bus5.mode      = 2'b00;
    bus5.in_valid  = 1'b0;
    bus5.out_ready = 1'b1;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid",    32'(bus.out_valid),  32'd0);
    check("rst.idx",      32'(bus.out_idx),    32'd0);
    check("rst.none",     32'(bus.out_none),   32'd0);
    check("rst.err",      32'(bus.out_err),    32'd0);
    check("rst.in_ready", 32'(bus.in_ready),   32'd1);
    check("rst.valid5",   32'(bus5.out_valid), 32'd0);
    rst = 1'b0;

    // Table: one vector per cycle with out_ready high, each checked one cycle later.
    @(negedge clk);
    drive(tbl[0].mode, tbl[0].vec);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].idx, tbl[i].none, tbl[i].err);
      check($sformatf("tbl[%0d].in_ready", i), 32'(bus.in_ready), 32'd1);
      if (i + 1 < NV) drive(tbl[i + 1].mode, tbl[i + 1].vec);
    end

    // Back-pressure: hold a result for three cycles, then consume and accept on one edge.
    drive(2'b00, 8'h04);
    @(negedge clk);
    expect_out("bp.first", 2, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    drive(2'b00, 8'h40);
    #1 check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_out($sformatf("bp.hold[%0d]", k), 2, 1'b0, 1'b0);
      check($sformatf("bp.hold[%0d].in_ready", k), 32'(bus.in_ready), 32'd0);
      drive(2'(k + 1), 8'(8'h81 >> k));
    end
    drive(2'b00, 8'h40);
    bus.out_ready = 1'b1;
    #1 check("bp.in_ready_high", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    expect_out("bp.replace", 6, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp.drain.valid", 32'(bus.out_valid), 32'd0);

    // Async reset between edges while a round-robin result is held (ptr was 7 -> grant 4).
    drive(2'b11, 8'h90);
    @(negedge clk);
    expect_out("ar.before", 4, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("ar.valid_now", 32'(bus.out_valid), 32'd0);
    check("ar.idx_now", 32'(bus.out_idx), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ar.idle.valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    drive(2'b11, 8'hFF);
    @(negedge clk);
    expect_out("ar.grant0", 0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("ar.grant1", 1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;

    // N=5: round-robin wraps from 4 to 0 and indices stay within 0..4.
    step5("n5.rr0",  2'b11, 5'b10001, 0, 1'b0, 1'b0);
    step5("n5.rr1",  2'b11, 5'b10001, 4, 1'b0, 1'b0);
    step5("n5.rr2",  2'b11, 5'b10001, 0, 1'b0, 1'b0);
    step5("n5.lsb",  2'b00, 5'b10000, 4, 1'b0, 1'b0);
    step5("n5.msb",  2'b01, 5'b11111, 4, 1'b0, 1'b0);
    step5("n5.zero", 2'b10, 5'b00000, 0, 1'b1, 1'b1);
    bus5.in_valid = 1'b0;
    @(negedge clk);
    check("n5.drain.valid", 32'(bus5.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prio_encoder_pipe.md
# prio_encoder_pipe

Parametrised, registered N-to-log2(N) encoder with valid/ready handshake on both sides, the general-purpose successor to the fixed 8-to-3 one-hot encoder. It sits between a request vector source and a downstream consumer of an index. It supports four run-time selectable encoding modes: LSB priority, MSB priority, strict one-hot with error flag, and round-robin. Each result carries "no input set" and error flags, and results are buffered in one output stage so back-pressure is handled without loss.

## Interface
- `N`, 8, number of input lines; ≥2, power of two not required.
- `W`, $clog2(N), index width; derived, not overridden.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_vec`  input  N  request/one-hot vector.
- `mode`  input  2  00 LSB-first, 01 MSB-first, 10 strict one-hot, 11 round-robin; sampled with `in_vec`.
- `in_valid`  input  1  `in_vec`/`mode` valid.
- `in_ready`  output  1  block can accept this cycle.
- `out_idx`  output  W  encoded index.
- `out_none`  output  1  accepted `in_vec` was all zero.
- `out_err`  output  1  strict mode: input not exactly one-hot.
- `out_valid`  output  1  result register holds an unconsumed result.
- `out_ready`  input  1  downstream accepts result.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Encoding is combinational on `in_vec`/`mode` and is captured into the output register on accept.
- `in_ready = !out_valid || out_ready`, combinational. A new result may be captured in the same cycle the old one is consumed.
- Mode 00: `out_idx` = lowest set bit index.
- Mode 01: `out_idx` = highest set bit index.
- Mode 10: exactly one bit set gives that index with `out_err=0`. Two or more bits set gives the lowest set index with `out_err=1`. Zero bits set gives `out_idx=0`, `out_none=1`, `out_err=1`.
- Mode 11: the search starts at `(ptr+1) mod N` and ascends with wrap-around. The first set bit found is granted. On accept with a nonzero vector, `ptr` ← granted index. Zero vector: `ptr` unchanged.
- `ptr` (W bits, internal) is updated only by accepted mode-11 transactions. Other modes leave it untouched, and mode changes do not reset it.
- Any mode, zero vector: `out_idx=0`, `out_none=1`. `out_err=1` only in mode 10.
- `out_err=0` in modes 00, 01 and 11 always.
- When N is not a power of two, `out_idx` never exceeds N-1. Round-robin wrap goes from N-1 to 0.
- Reset values: `out_valid=0`, `out_idx=0`, `out_none=0`, `out_err=0`, `ptr=N-1`. As a result, the first round-robin search after reset begins at bit 0.

## Timing
- Latency: 1 cycle, from the accept edge to `out_valid=1` with the result.
- Throughput: 1 result/cycle when `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, all of `out_idx`/`out_none`/`out_err`/`out_valid` are held stable, `in_ready=0`, and `ptr` does not change.
- Consume and accept on the same edge: the new result replaces the old one and `out_valid` stays 1.
- Consume with no accept: `out_valid` → 0 on that edge. Output data may hold its stale value.
- Reset asserted mid-operation clears `out_valid` and `ptr` immediately, without waiting for a clock edge. Any pending result is discarded, and no accept occurs while `rst=1`.
- `in_vec` and `mode` are ignored when not accepted and need not be stable.

## Test plan
- Reset, then N=8, mode 00, with `out_ready=1`. Inputs 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80 on consecutive cycles. Required: `out_idx` = 0 through 7 on consecutive cycles, each 1 cycle after its input, with `out_none=0` and `out_err=0`.
- Mode 00 vs 01 with `in_vec`=8'h5A. Required: mode 00 gives `out_idx=1` and mode 01 gives `out_idx=6`. Then send 8'h00. Required: `out_idx=0`, `out_none=1`, `out_err=0`.
- Mode 10 with inputs 8'h10, 8'h30 and 8'h00. Required:
  - 8'h10 → `idx=4`, `err=0`.
  - 8'h30 → `idx=4`, `err=1`.
  - 8'h00 → `idx=0`, `none=1`, `err=1`.
- Mode 11, 8'h91 held for 4 accepts after reset. Required: grants 0, 4, 7, 0. Then insert an 8'h00 accept. Required: `none=1` and the next grant from 8'h91 is 4 (ptr unchanged).
- Back-pressure: `out_ready=0` for 3 cycles with `in_valid=1`. Required: `in_ready=0` and the output is held. Then `out_ready=1`. Required: the held result is consumed and the new one is captured on the same edge, so `out_valid` stays 1.
- Asynchronous `rst` pulse between clock edges while `out_valid=1` in mode 11. Required: `out_valid=0` immediately. After release, the first grant from 8'hFF is index 0.
